// File: rtl/rv64_decode_execute_pkg.sv
// rv64_decode_execute_pkg: opcodes, immediate formats, ALU and branch codes shared across the ID/EX slice
package rv64_decode_execute_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;
    localparam int F7_ALT_BIT = 5;
endpackage

// File: rtl/rv64_decode_execute_alu.sv
// rv64_decode_execute_alu: 64-bit RV64I integer ALU, purely combinational
module rv64_decode_execute_alu
    import rv64_decode_execute_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    logic [5:0] sh;
    assign sh = b[5:0];
    always_comb begin
        y = '0;
        case (funct3)
            ALU_ADD:  y = alt ? a - b : a + b;
            ALU_SLL:  y = a << sh;
            ALU_SLT:  y = {63'd0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {63'd0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SR:   y = alt ? 64'($signed(a) >>> sh) : a >> sh;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/rv64_decode_execute.sv
// rv64_decode_execute: ID-stage control decode and branch resolution, EX-stage ALU with a holdable result register
module rv64_decode_execute
    import rv64_decode_execute_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        branch,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    output logic [2:0]  imm_type,
    output logic        alu_src_b_sel,
    input  logic [63:0] id_rs1_data,
    input  logic [63:0] id_rs2_data,
    input  logic [63:0] id_pc,
    input  logic [63:0] id_imm,
    output logic        take_branch,
    output logic [63:0] branch_target,
    input  logic [2:0]  ex_funct3,
    input  logic [6:0]  ex_funct7,
    input  logic [63:0] ex_rs1,
    input  logic [63:0] ex_rs2,
    input  logic        ex_hold,
    output logic [63:0] ex_result,
    output logic [63:0] ex_result_q
);
    logic eq, lt, ltu, cond;
    logic unused_funct7;
    assign unused_funct7 = ^{ex_funct7[6], ex_funct7[4:0]};
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        branch        = 1'b0;
        alu_src_b_sel = 1'b0;
        imm_type      = IMM_I;
        alu_funct3    = ALU_ADD;
        alu_funct7    = '0;
        case (opcode)
            OP_R: begin
                reg_write  = 1'b1;
                alu_funct3 = funct3;
                alu_funct7 = funct7;
            end
            OP_IMM: begin
                reg_write     = 1'b1;
                alu_src_b_sel = 1'b1;
                alu_funct3    = funct3;
                // only shifts carry funct7; otherwise imm[11:5] would turn ADDI into SUB
                alu_funct7    = (funct3 == ALU_SLL || funct3 == ALU_SR) ? funct7 : '0;
            end
            OP_LOAD: begin
                mem_read      = 1'b1;
                reg_write     = 1'b1;
                alu_src_b_sel = 1'b1;
            end
            OP_STORE: begin
                mem_write     = 1'b1;
                alu_src_b_sel = 1'b1;
                imm_type      = IMM_S;
            end
            OP_BRANCH: begin
                branch     = 1'b1;
                alu_funct3 = funct3;
                imm_type   = IMM_B;
            end
            default: ;
        endcase
    end
    assign eq  = id_rs1_data == id_rs2_data;
    assign lt  = $signed(id_rs1_data) < $signed(id_rs2_data);
    assign ltu = id_rs1_data < id_rs2_data;
    assign cond = alu_funct3 == BR_EQ  ? eq   :
                  alu_funct3 == BR_NE  ? !eq  :
                  alu_funct3 == BR_LT  ? lt   :
                  alu_funct3 == BR_GE  ? !lt  :
                  alu_funct3 == BR_LTU ? ltu  :
                  alu_funct3 == BR_GEU ? !ltu : 1'b0;
    assign take_branch   = branch & cond;
    assign branch_target = id_pc + id_imm;
    rv64_decode_execute_alu u_alu (
        .funct3 (ex_funct3),
        .alt    (ex_funct7[F7_ALT_BIT]),
        .a      (ex_rs1),
        .b      (ex_rs2),
        .y      (ex_result)
    );
    always_ff @(posedge clk) begin
        if (rst)
            ex_result_q <= '0;
        else if (!ex_hold)
            ex_result_q <= ex_result;
    end
endmodule

// File: tb/tb_rv64_decode_execute.sv
// tb_rv64_decode_execute: directed steps with a scoreboard of expected outputs checked by immediate assertions
module tb_rv64_decode_execute;
    logic        clk = 1'b0, rst = 1'b1;
    logic [6:0]  opcode = '0, funct7 = '0, ex_funct7 = '0;
    logic [2:0]  funct3 = '0, ex_funct3 = '0;
    logic        mem_read, mem_write, reg_write, branch, alu_src_b_sel, take_branch;
    logic [2:0]  alu_funct3, imm_type;
    logic [6:0]  alu_funct7;
    logic [63:0] id_rs1_data = '0, id_rs2_data = '0, id_pc = '0, id_imm = '0;
    logic [63:0] ex_rs1 = '0, ex_rs2 = '0, branch_target, ex_result, ex_result_q;
    logic        ex_hold = 1'b0;

    typedef enum int {S_MR, S_MW, S_RW, S_BR, S_AF3, S_AF7, S_IMM, S_SRC, S_TB, S_TGT, S_RES, S_RQ} sel_t;
    typedef struct { sel_t sel; logic [63:0] exp; string tag; } exp_t;
    exp_t sb[$];
    int n_checks = 0, n_pass = 0, n_fail = 0;

    rv64_decode_execute dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .branch(branch),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .imm_type(imm_type),
        .alu_src_b_sel(alu_src_b_sel), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_pc(id_pc), .id_imm(id_imm), .take_branch(take_branch), .branch_target(branch_target),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_hold(ex_hold), .ex_result(ex_result), .ex_result_q(ex_result_q)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] observe(sel_t s);
        case (s)
            S_MR:  return {63'd0, mem_read};
            S_MW:  return {63'd0, mem_write};
            S_RW:  return {63'd0, reg_write};
            S_BR:  return {63'd0, branch};
            S_AF3: return {61'd0, alu_funct3};
            S_AF7: return {57'd0, alu_funct7};
            S_IMM: return {61'd0, imm_type};
            S_SRC: return {63'd0, alu_src_b_sel};
            S_TB:  return {63'd0, take_branch};
            S_TGT: return branch_target;
            S_RES: return ex_result;
            default: return ex_result_q;
        endcase
    endfunction

    task automatic push(sel_t s, logic [63:0] v, string tag);
        sb.push_back('{s, v, tag});
    endtask

    task automatic drain();
        exp_t e;
        logic [63:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            n_checks++;
            assert (o === e.exp) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: got 0x%016h expected 0x%016h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic dec(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        opcode = op; funct3 = f3; funct7 = f7;
    endtask

    task automatic alu(logic [2:0] f3, logic [6:0] f7, logic [63:0] a, logic [63:0] b);
        ex_funct3 = f3; ex_funct7 = f7; ex_rs1 = a; ex_rs2 = b;
    endtask

    initial begin
        @(posedge clk); #1;
        push(S_RQ, 64'd0, "reset_q");
        drain();
        rst = 1'b0;

        dec(7'b0110011, 3'b000, 7'h20); alu(3'b000, 7'h20, 64'd5, 64'd7);
        push(S_RW, 1, "r_reg_write"); push(S_SRC, 0, "r_src_b"); push(S_AF7, 64'h20, "r_funct7");
        push(S_MR, 0, "r_mem_read"); push(S_RES, 64'hFFFF_FFFF_FFFF_FFFE, "sub_5_7");
        #1 drain();

        dec(7'b0010011, 3'b000, 7'h20);
        push(S_AF7, 0, "addi_funct7"); push(S_SRC, 1, "addi_src_b"); push(S_RW, 1, "addi_reg_write");
        #1 drain();
        dec(7'b0010011, 3'b101, 7'h20);
        push(S_AF7, 64'h20, "srai_funct7"); push(S_AF3, 5, "srai_funct3");
        #1 drain();

        alu(3'b101, 7'h20, 64'h8000_0000_0000_0000, 64'd63);
        push(S_RES, 64'hFFFF_FFFF_FFFF_FFFF, "sra_63");
        #1 drain();
        alu(3'b101, 7'h00, 64'h8000_0000_0000_0000, 64'd63);
        push(S_RES, 64'd1, "srl_63");
        #1 drain();
        alu(3'b101, 7'h21, 64'h8000_0000_0000_0000, 64'hFFC0);
        push(S_RES, 64'h8000_0000_0000_0000, "sra_shamt_low6");
        #1 drain();
        alu(3'b001, 7'h00, 64'd1, 64'd63);
        push(S_RES, 64'h8000_0000_0000_0000, "sll_63");
        #1 drain();
        alu(3'b010, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        push(S_RES, 1, "slt_neg");
        #1 drain();
        alu(3'b011, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        push(S_RES, 0, "sltu_big");
        #1 drain();
        alu(3'b000, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        push(S_RES, 1, "add_wrap");
        #1 drain();
        alu(3'b100, 7'h00, 64'hF0F0, 64'hFF00);
        push(S_RES, 64'h0FF0, "xor");
        #1 drain();
        alu(3'b110, 7'h00, 64'hF0F0, 64'hFF00);
        push(S_RES, 64'hFFF0, "or");
        #1 drain();
        alu(3'b111, 7'h00, 64'hF0F0, 64'hFF00);
        push(S_RES, 64'hF000, "and");
        #1 drain();

        dec(7'b1100011, 3'b100, 7'h00);
        id_rs1_data = '1; id_rs2_data = 64'd1; id_pc = 64'h100; id_imm = -64'sd8;
        push(S_TB, 1, "blt_taken"); push(S_TGT, 64'hF8, "blt_target");
        push(S_BR, 1, "br_branch"); push(S_IMM, 2, "br_imm_type"); push(S_RW, 0, "br_reg_write");
        #1 drain();
        funct3 = 3'b110;
        push(S_TB, 0, "bltu_not_taken");
        #1 drain();
        funct3 = 3'b111;
        push(S_TB, 1, "bgeu_taken");
        #1 drain();
        funct3 = 3'b010;
        push(S_TB, 0, "br_f3_010");
        #1 drain();
        funct3 = 3'b000; id_rs2_data = '1;
        push(S_TB, 1, "beq_taken");
        #1 drain();

        dec(7'b0000011, 3'b011, 7'h20);
        push(S_MR, 1, "ld_mem_read"); push(S_RW, 1, "ld_reg_write"); push(S_AF3, 0, "ld_funct3");
        push(S_AF7, 0, "ld_funct7"); push(S_SRC, 1, "ld_src_b"); push(S_IMM, 0, "ld_imm_type");
        #1 drain();
        dec(7'b0100011, 3'b010, 7'h20);
        push(S_MW, 1, "st_mem_write"); push(S_IMM, 1, "st_imm_type"); push(S_RW, 0, "st_reg_write");
        push(S_AF3, 0, "st_funct3");
        #1 drain();
        dec(7'b1111111, 3'b101, 7'h20);
        push(S_MR, 0, "nop_mem_read"); push(S_MW, 0, "nop_mem_write"); push(S_RW, 0, "nop_reg_write");
        push(S_BR, 0, "nop_branch"); push(S_SRC, 0, "nop_src_b"); push(S_TB, 0, "nop_take");
        push(S_AF3, 0, "nop_funct3"); push(S_AF7, 0, "nop_funct7");
        #1 drain();

        alu(3'b000, 7'h00, 64'h1234, 64'd0);
        @(posedge clk); #1;
        push(S_RQ, 64'h1234, "q_capture");
        drain();
        ex_hold = 1'b1; alu(3'b000, 7'h00, 64'h5555, 64'd0);
        @(posedge clk); #1;
        push(S_RQ, 64'h1234, "q_hold"); push(S_RES, 64'h5555, "res_during_hold");
        drain();
        rst = 1'b1;
        @(posedge clk); #1;
        push(S_RQ, 0, "q_rst_over_hold"); push(S_RES, 64'h5555, "res_during_rst");
        drain();
        rst = 1'b0; ex_hold = 1'b0;
        @(posedge clk); #1;
        push(S_RQ, 64'h5555, "q_after_rst");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
